// File: rtl/id_operand_stage_pkg.sv
// Shared types and constants for the ID operand-fetch stage: conditional-write
// encodings, the decoder control bundle width and the write-enable resolution helper.
package id_operand_stage_pkg;

  localparam int ALUOP_W       = 8;
  localparam int ALUSEL_W      = 3;
  localparam int CTRL_BUNDLE_W = ALUOP_W + ALUSEL_W;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    COND_WR_NONE  = 2'b00,
    COND_WR_NZ    = 2'b01,
    COND_WR_Z     = 2'b10,
    COND_WR_NEVER = 2'b11
  } cond_wr_e;

  // MOVN/MOVZ gate the decoder write enable on the resolved second operand.
  function automatic logic wr_resolve(input logic wr_en, input logic [1:0] cond_wr,
                                      input logic op2_zero);
    logic ok;
    case (cond_wr)
      COND_WR_NONE: ok = 1'b1;
      COND_WR_NZ:   ok = ~op2_zero;
      COND_WR_Z:    ok = op2_zero;
      default:      ok = 1'b0;
    endcase
    return wr_en & ok;
  endfunction

endpackage

// File: rtl/id_operand_stage_operand_fwd_mux.sv
// One source operand: immediate, hardwired zero, youngest matching forward, or regfile.
// Purely combinational; raises hazard when the winning forward source is still pending.
module operand_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                      rd_en,
  input  logic [REG_AW-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         imm,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         op,
  output logic                      hazard
);

  logic found;

  always_comb begin
    op     = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    // Only the first (youngest) match decides; older writers of the same register are stale.
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == rd_addr)) begin
        found = 1'b1;
        if (fwd_pending[i]) hazard = 1'b1;
        else                op     = fwd_data[i*DATA_W +: DATA_W];
      end
    end
    if (!rd_en) begin
      op     = imm;
      hazard = 1'b0;
    end else if (rd_addr == '0) begin
      op     = DATA_W'(ZeroWord);
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand fetch, load-use hazard and ID/EX register; 1-cycle latency.
// EX backpressure holds the register without bubbles; hazards drain a bubble and stall ID.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int CTRL_W  = CTRL_BUNDLE_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      rd1_en,
  input  logic                      rd2_en,
  input  logic [REG_AW-1:0]         rd1_addr,
  input  logic [REG_AW-1:0]         rd2_addr,
  input  logic [DATA_W-1:0]         imm,
  input  logic                      wr_en,
  input  logic [REG_AW-1:0]         wr_addr,
  input  logic [1:0]                cond_wr,
  input  logic [DATA_W-1:0]         rf_data1,
  input  logic [DATA_W-1:0]         rf_data2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pc,
  output logic [DATA_W-1:0]         out_op1,
  output logic [DATA_W-1:0]         out_op2,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic                      out_wr_en,
  output logic [REG_AW-1:0]         out_wr_addr,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [DATA_W-1:0] op1, op2;
  logic              haz1, haz2;
  logic              hazard, load_en, wr_final;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_op1_q, out_op1_d;
  logic [DATA_W-1:0] out_op2_q, out_op2_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              out_wr_en_q, out_wr_en_d;
  logic [REG_AW-1:0] out_wr_addr_q, out_wr_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux1 (
    .rd_en(rd1_en), .rd_addr(rd1_addr), .imm(imm), .rf_data(rf_data1),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .op(op1), .hazard(haz1)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux2 (
    .rd_en(rd2_en), .rd_addr(rd2_addr), .imm(imm), .rf_data(rf_data2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .op(op2), .hazard(haz2)
  );

  assign hazard   = in_valid & (haz1 | haz2);
  assign load_en  = out_ready | ~out_valid_q;
  assign in_ready = load_en & ~hazard & ~flush;
  assign wr_final = wr_resolve(wr_en, cond_wr, op2 == '0);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    out_ctrl_d    = out_ctrl_q;
    out_wr_en_d   = out_wr_en_q;
    out_wr_addr_d = out_wr_addr_q;
    stall_cnt_d   = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
      out_wr_en_d = 1'b0;
    end else if (load_en) begin
      if (in_valid && !hazard) begin
        out_valid_d   = 1'b1;
        out_pc_d      = in_pc;
        out_op1_d     = op1;
        out_op2_d     = op2;
        out_ctrl_d    = in_ctrl;
        out_wr_en_d   = wr_final;
        out_wr_addr_d = wr_addr;
      end else begin
        out_valid_d = 1'b0;
        out_wr_en_d = 1'b0;
      end
    end

    // Counts every stalled cycle, including those overlapping EX backpressure.
    if (hazard && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_ctrl_q    <= '0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
      out_ctrl_q    <= out_ctrl_d;
      out_wr_en_q   <= out_wr_en_d;
      out_wr_addr_q <= out_wr_addr_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
